alu_mc: RTL
===========

// Module: alu_mc
// PURPOSE
// - Parametrised multi-cycle ALU with a valid/ready handshake on input and output.
// - Single-cycle ops: add, and, xor, sll, sub, srai, srl.
// - Iterative ops: mul, mulh, div, rem.
// - Sits in the EX stage; the hazard unit stalls the pipeline while in_ready_o or out_valid_o is low.
// PARAMETERS
// - WIDTH  32  operand/result width; power of two, >= 8. SHAMT_W = $clog2(WIDTH) (localparam).
// - ITER   WIDTH  cycles spent in BUSY for mul/mulh/div/rem; must be >= 1.
// PORTS
// - clk_i        in   1      clock, rising edge
// - rst_i        in   1      asynchronous, active-low reset
// - in_valid_i   in   1      operation request
// - in_ready_o   out  1      block can accept (high only in IDLE)
// - ALUCtrl_i    in   4      opcode, see BEHAVIOUR
// - a_i, b_i     in   WIDTH  operands, signed two's complement
// - flush_i      in   1      synchronous abort of any in-flight op
// - out_valid_o  out  1      data_o/dz_o valid
// - out_ready_i  in   1      consumer takes the result
// - data_o       out  WIDTH  result
// - dz_o         out  1      divide-by-zero flag for div/rem; 0 for all other ops
// - busy_o       out  1      high in BUSY
// BEHAVIOUR
// - Opcodes:
//   - 0000 add; 0001 and; 0010 xor; 0011 sll by b[SHAMT_W-1:0]; 0100 sub.
//   - 0101 mul: low WIDTH bits of signed a*b.
//   - 0110 srai: arithmetic shift right by b[SHAMT_W-1:0].
//   - 0111 mulh: high WIDTH bits of signed 2*WIDTH product.
//   - 1000 div: signed, truncates toward zero.
//   - 1001 rem: sign follows dividend.
//   - 1010 srl: logical shift right.
//   - 1011-1111: result 0, single-cycle.
// - Add/sub wrap modulo 2^WIDTH; no overflow flag.
// - Div by zero: div -> all ones, rem -> a, dz_o=1.
// - Div overflow (a = most negative, b = -1): div -> a, rem -> 0, dz_o=0.
// - FSM states: IDLE, BUSY, DONE.
// - Reset (asynchronous, any state): state=IDLE; data_o=0, out_valid_o=0, dz_o=0, busy_o=0; in_ready_o=1 once rst_i deasserts.
// - IDLE: in_ready_o=1. Accept on edge where in_valid_i & in_ready_o; a_i, b_i, ALUCtrl_i are captured at that edge.
//   - Single-cycle op -> DONE at that same edge; out_valid_o high in the following cycle (latency 1).
//   - Iterative op -> BUSY with counter=ITER-1.
// - BUSY: in_ready_o=0, busy_o=1. Counter decrements each edge; at counter==0 -> DONE.
//   - out_valid_o rises exactly ITER+1 edges after acceptance.
// - DONE: out_valid_o=1. data_o and dz_o are held stable until out_ready_i is sampled high -> IDLE.
//   - in_ready_o rises the cycle after the handshake; no back-to-back accept in DONE.
// - flush_i: if high at an edge in BUSY or DONE -> IDLE. Result is discarded, out_valid_o=0 next cycle, data_o keeps last value.
//   - flush_i in IDLE with in_valid_i high: the op is NOT accepted.
//   - flush_i has priority over accept and over the out handshake.
// - in_valid_i outside IDLE is ignored; inputs are not required stable after acceptance.
// - busy_o and out_valid_o are never high together; in_ready_o and out_valid_o are never high together.
// TESTING
// - Reset mid-BUSY of mul: rst_i low -> out_valid_o=0, busy_o=0, data_o=0 immediately; new op accepted after release.
// - add 0x7FFFFFFF+1 -> data_o=0x80000000 one cycle after accept; srai 0x80000000>>4 -> 0xF8000000; srl same -> 0x08000000.
// - mul -6*7 -> 0xFFFFFFD6; mulh 0x80000000*0x80000000 -> 0x40000000; out_valid_o exactly ITER+1 edges after accept.
// - div -7/2 -> 0xFFFFFFFD, rem -> 0xFFFFFFFF; div 5/0 -> 0xFFFFFFFF with dz_o=1; div 0x80000000/-1 -> 0x80000000.
// - Backpressure: out_ready_i low 5 cycles in DONE -> data_o stable, in_ready_o=0 throughout; accept resumes the cycle after handshake.
// - flush_i at BUSY cycle 3 of div -> IDLE next cycle, no out_valid_o; next add 2+3 returns 5.

Source files
------------

// File: rtl/alu_mc_if.sv
// Request/result bundle between the EX-stage issue logic and the multi-cycle ALU.
// The ALU sits on the slave side; the pipeline (or a bench) drives the master side.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [3:0]       ALUCtrl_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] data_o;
    logic             dz_o;
    logic             busy_o;

    modport master (
        output in_valid_i, ALUCtrl_i, a_i, b_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, dz_o, busy_o
    );

    modport slave (
        input  in_valid_i, ALUCtrl_i, a_i, b_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, dz_o, busy_o
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: shifts and logic ops finish in one cycle, mul/mulh/div/rem hold
// the operands in BUSY for ITER cycles so the arithmetic has a multicycle path.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input logic       clk_i,
    input logic       rst_i,
    alu_mc_if.slave   bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, next_state;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     data_q;
    logic                 dz_q;
    logic                 accept;

    logic [3:0]           op_s;
    logic [WIDTH-1:0]     a_s, b_s;
    logic [SHAMT_W-1:0]   shamt;
    logic [2*WIDTH-1:0]   a_ext, b_ext, prod;
    logic [WIDTH-1:0]     a_mag, b_mag, quo_mag, rem_mag;
    logic [WIDTH-1:0]     res;
    logic                 res_dz;

    function automatic logic is_iter(input logic [3:0] op);
        return op inside {4'b0101, 4'b0111, 4'b1000, 4'b1001};
    endfunction

    assign accept = (state == IDLE) && bus.in_valid_i && !bus.flush_i;

    // In IDLE the live inputs feed the datapath; afterwards the captured copies do.
    assign op_s = (state == IDLE) ? bus.ALUCtrl_i : op_q;
    assign a_s  = (state == IDLE) ? bus.a_i       : a_q;
    assign b_s  = (state == IDLE) ? bus.b_i       : b_q;

    always_comb begin
        shamt   = b_s[SHAMT_W-1:0];
        a_ext   = {{WIDTH{a_s[WIDTH-1]}}, a_s};
        b_ext   = {{WIDTH{b_s[WIDTH-1]}}, b_s};
        prod    = a_ext * b_ext;
        a_mag   = a_s[WIDTH-1] ? -a_s : a_s;
        b_mag   = b_s[WIDTH-1] ? -b_s : b_s;
        quo_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
        rem_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
        res     = '0;
        res_dz  = 1'b0;
        case (op_s)
            4'b0000: res = a_s + b_s;
            4'b0001: res = a_s & b_s;
            4'b0010: res = a_s ^ b_s;
            4'b0011: res = a_s << shamt;
            4'b0100: res = a_s - b_s;
            4'b0101: res = prod[WIDTH-1:0];
            4'b0110: res = $signed(a_s) >>> shamt;
            4'b0111: res = prod[2*WIDTH-1:WIDTH];
            // Sign-magnitude division; most-negative / -1 naturally wraps back to a.
            4'b1000: begin
                if (b_s == '0) begin
                    res    = '1;
                    res_dz = 1'b1;
                end else begin
                    res = (a_s[WIDTH-1] ^ b_s[WIDTH-1]) ? -quo_mag : quo_mag;
                end
            end
            4'b1001: begin
                if (b_s == '0) begin
                    res    = a_s;
                    res_dz = 1'b1;
                end else begin
                    res = a_s[WIDTH-1] ? -rem_mag : rem_mag;
                end
            end
            4'b1010: res = a_s >> shamt;
            default: res = '0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = is_iter(bus.ALUCtrl_i) ? BUSY : DONE;
            BUSY: begin
                if (bus.flush_i)     next_state = IDLE;
                else if (cnt == '0)  next_state = DONE;
            end
            DONE: if (bus.flush_i || bus.out_ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= next_state;
    end

    // Result registers only load on entry to DONE, so a flush leaves the last result visible.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            data_q <= '0;
            dz_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= bus.ALUCtrl_i;
                a_q  <= bus.a_i;
                b_q  <= bus.b_i;
                cnt  <= CNT_W'(ITER - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (next_state == DONE && state != DONE) begin
                data_q <= res;
                dz_q   <= res_dz;
            end
        end
    end

    assign bus.in_ready_o  = (state == IDLE) && rst_i;
    assign bus.busy_o      = (state == BUSY);
    assign bus.out_valid_o = (state == DONE);
    assign bus.data_o      = data_q;
    assign bus.dz_o        = dz_q;
endmodule
